// File: rtl/bandit_environment.sv
// 256-armed Bernoulli bandit: one arm index in, one signed reward out; optional drift under BANDIT_ENVIRONMENT_DRIFT_EN.
// Latency: acceptance edge -> one DRAW cycle -> reward_valid; at most one transaction per 3 cycles.
// Backpressure: action_ready low while a transaction is outstanding; reward held stable until reward_ready.
module bandit_environment #(
    parameter logic [7:0]        SEED         = 8'h5a,
    parameter logic [7:0]        TAPS         = 8'hb1,
    parameter logic [7:0]        BEST_ARM     = 8'd3,
    parameter logic [7:0]        HIGH_PROB    = 8'd204,
    parameter logic [7:0]        LOW_PROB     = 8'd51,
    parameter logic signed [7:0] REWARD_HI    = 8'sd64,
    parameter logic signed [7:0] REWARD_LO    = -8'sd64,
    parameter logic [15:0]       DRIFT_PERIOD = 16'd1024,
    parameter logic [7:0]        DRIFT_STEP   = 8'd37
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        action_valid,
    input  logic [7:0]  action_data,
    output logic        action_ready,
    output logic        reward_valid,
    output logic [7:0]  reward_data,
    input  logic        reward_ready,
    output logic [7:0]  best_arm,
    output logic [15:0] pull_count,
    output logic [15:0] best_count
);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {IDLE, DRAW, REWARD} state_t;

    state_t     state;
    logic [7:0] arm;
    logic [7:0] lfsr;
    logic [7:0] draw_prob;
    logic       accept;
    logic       handshake;
    logic       hit;

    assign accept    = action_valid && action_ready;
    assign handshake = reward_valid && reward_ready;
    assign hit       = (action_data == best_arm);
    assign draw_prob = (arm == best_arm) ? HIGH_PROB : LOW_PROB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_INIT;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & TAPS)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            action_ready <= 1'b1;
            reward_valid <= 1'b0;
            reward_data  <= 8'h00;
            arm          <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        arm          <= action_data;
                        action_ready <= 1'b0;
                        state        <= DRAW;
                    end
                end
                DRAW: begin
                    reward_data  <= (lfsr < draw_prob) ? REWARD_HI : REWARD_LO;
                    reward_valid <= 1'b1;
                    state        <= REWARD;
                end
                REWARD: begin
                    if (handshake) begin
                        reward_valid <= 1'b0;
                        action_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    reward_valid <= 1'b0;
                    action_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pull_count <= 16'h0000;
            best_count <= 16'h0000;
        end else if (accept) begin
            if (pull_count != 16'hffff) begin
                pull_count <= pull_count + 16'd1;
            end
            if (hit && best_count != 16'hffff) begin
                best_count <= best_count + 16'd1;
            end
        end
    end

`ifdef BANDIT_ENVIRONMENT_DRIFT_EN
    logic [15:0] txn_count;

    // best_arm only moves at a reward handshake, so it is stable from acceptance through DRAW.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_count <= 16'h0000;
            best_arm  <= BEST_ARM;
        end else if (handshake) begin
            if (txn_count == DRIFT_PERIOD - 16'd1) begin
                txn_count <= 16'h0000;
                best_arm  <= best_arm + DRIFT_STEP;
            end else begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end
`else
    logic unused_drift;

    assign best_arm     = BEST_ARM;
    assign unused_drift = ^{DRIFT_PERIOD, DRIFT_STEP};
`endif

endmodule

// File: tb/tb_bandit_environment.sv
// Directed bench for bandit_environment: two instances (deterministic probabilities / default probabilities with short drift period)
// driven in lockstep and checked every cycle against a transaction-level model, plus literal boundary expectations.
module tb_bandit_environment;
`ifdef BANDIT_ENVIRONMENT_DRIFT_EN
    localparam bit DRIFT_ON = 1'b1;
`else
    localparam bit DRIFT_ON = 1'b0;
`endif
    localparam int         PERIOD [2] = '{1024, 4};
    localparam logic [7:0] HP     [2] = '{8'd255, 8'd204};
    localparam logic [7:0] LP     [2] = '{8'd0, 8'd51};
    localparam logic [7:0] R_HI = 8'h40;
    localparam logic [7:0] R_LO = 8'hc0;

    logic        clock = 1'b0;
    logic        reset;
    logic        action_valid;
    logic [7:0]  action_data;
    logic        reward_ready;
    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [7:0]  dat  [2];
    logic [7:0]  best [2];
    logic [15:0] pull [2];
    logic [15:0] bcnt [2];

    int vectors = 0;
    int errors  = 0;

    // Transaction-level model state
    int          cyc;
    int          m_emit;
    logic        m_pend;
    logic [7:0]  m_lfsr;
    logic [15:0] m_pull;
    logic [7:0]  m_best  [2];
    logic [15:0] m_bcnt  [2];
    int          m_hs    [2];
    logic [7:0]  m_pdata [2];
    logic [7:0]  m_shown [2];

    always #5 clock = ~clock;

    bandit_environment #(.HIGH_PROB(8'd255), .LOW_PROB(8'd0)) dut_a (
        .clock(clock), .reset(reset),
        .action_valid(action_valid), .action_data(action_data), .action_ready(rdy[0]),
        .reward_valid(vld[0]), .reward_data(dat[0]), .reward_ready(reward_ready),
        .best_arm(best[0]), .pull_count(pull[0]), .best_count(bcnt[0])
    );

    bandit_environment #(.DRIFT_PERIOD(16'd4)) dut_b (
        .clock(clock), .reset(reset),
        .action_valid(action_valid), .action_data(action_data), .action_ready(rdy[1]),
        .reward_valid(vld[1]), .reward_data(dat[1]), .reward_ready(reward_ready),
        .best_arm(best[1]), .pull_count(pull[1]), .best_count(bcnt[1])
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hb1)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dut=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_emit = 0;
        m_pend = 1'b0;
        m_lfsr = 8'h5a;
        m_pull = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            m_best[i]  = 8'd3;
            m_bcnt[i]  = 16'h0000;
            m_hs[i]    = 0;
            m_pdata[i] = 8'h00;
            m_shown[i] = 8'h00;
        end
    endtask

    // Apply one clock edge to the model using the inputs the bench is driving.
    task automatic model_edge();
        logic hs;
        logic acc;
        logic hit;
        hs  = m_pend && (cyc >= m_emit) && reward_ready;
        acc = !m_pend && action_valid;
        cyc++;
        m_lfsr = lfsr_next(m_lfsr);
        if (hs) begin
            m_pend = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_hs[i]++;
                if (DRIFT_ON && m_hs[i] == PERIOD[i]) begin
                    m_hs[i]   = 0;
                    m_best[i] = m_best[i] + 8'd37;
                end
            end
        end
        if (acc) begin
            m_pend = 1'b1;
            m_emit = cyc + 1;
            if (m_pull != 16'hffff) m_pull++;
            for (int i = 0; i < 2; i++) begin
                hit = (action_data == m_best[i]);
                if (hit && m_bcnt[i] != 16'hffff) m_bcnt[i]++;
                // The draw sees the LFSR value present in the cycle right after acceptance.
                m_pdata[i] = (m_lfsr < (hit ? HP[i] : LP[i])) ? R_HI : R_LO;
            end
        end
        if (m_pend && cyc == m_emit) begin
            for (int i = 0; i < 2; i++) m_shown[i] = m_pdata[i];
        end
    endtask

    task automatic compare_all();
        logic exp_valid;
        exp_valid = m_pend && (cyc >= m_emit);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("action_ready[%0d]", i), 16'(rdy[i]), 16'(!m_pend));
            chk($sformatf("reward_valid[%0d]", i), 16'(vld[i]), 16'(exp_valid));
            chk($sformatf("reward_data[%0d]", i), 16'(dat[i]), 16'(m_shown[i]));
            chk($sformatf("best_arm[%0d]", i), 16'(best[i]), 16'(m_best[i]));
            chk($sformatf("pull_count[%0d]", i), pull[i], m_pull);
            chk($sformatf("best_count[%0d]", i), bcnt[i], m_bcnt[i]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic txn(input logic [7:0] arm, input int gap);
        action_valid = 1'b1;
        action_data  = arm;
        tick();
        action_valid = 1'b0;
        for (int k = 0; k < 10 && m_pend; k++) tick();
        chk("txn_done_ready", 16'(rdy[0]), 16'd1);
        repeat (gap) tick();
    endtask

    // Time an acceptance so the draw sees LFSR value r, then pin the reward literally.
    task automatic draw_at(input string name, input logic [7:0] r, input logic [7:0] arm,
                           input int inst, input logic [7:0] exp);
        for (int k = 0; k < 300 && lfsr_next(m_lfsr) != r; k++) tick();
        action_valid = 1'b1;
        action_data  = arm;
        tick();
        action_valid = 1'b0;
        tick();
        chk(name, 16'(dat[inst]), 16'(exp));
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        action_valid = 1'b0;
        action_data  = 8'h00;
        reward_ready = 1'b1;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_action_ready", 16'(rdy[i]), 16'd1);
            chk("reset_reward_valid", 16'(vld[i]), 16'd0);
            chk("reset_pull_count", pull[i], 16'd0);
            chk("reset_best_count", bcnt[i], 16'd0);
            chk("reset_best_arm", 16'(best[i]), 16'd3);
        end

        // Driven after edge N, accepted at N+1, reward visible after N+2.
        action_valid = 1'b1;
        action_data  = 8'd7;
        tick();
        action_valid = 1'b0;
        action_data  = 8'hee;
        chk("arm7_valid_after_n1", 16'(vld[0]), 16'd0);
        tick();
        chk("arm7_valid_after_n2", 16'(vld[0]), 16'd1);
        chk("arm7_reward_data", 16'(dat[0]), 16'h00c0);
        chk("arm7_pull_count", pull[0], 16'd1);
        chk("arm7_best_count", bcnt[0], 16'd0);
        tick();
        chk("arm7_ready_after_hs", 16'(rdy[0]), 16'd1);

        for (int i = 0; i < 20; i++) txn(8'd3, 0);
        chk("arm3x20_best_count", bcnt[0], 16'd20);
        chk("arm3x20_pull_count", pull[0], 16'd21);

        // Backpressure: reward held, action pulses ignored.
        reward_ready = 1'b0;
        action_valid = 1'b1;
        action_data  = 8'd5;
        tick();
        action_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            action_valid = (k % 2 == 0);
            action_data  = 8'd3 + 8'(k);
            tick();
            chk("hold_reward_valid", 16'(vld[0]), 16'd1);
            chk("hold_pull_count", pull[0], 16'd22);
        end
        action_valid = 1'b0;
        reward_ready = 1'b1;
        tick();
        chk("hold_release_ready", 16'(rdy[0]), 16'd1);

        // Reset in the middle of DRAW.
        action_valid = 1'b1;
        action_data  = 8'd9;
        tick();
        action_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midreset_reward_valid", 16'(vld[i]), 16'd0);
            chk("midreset_action_ready", 16'(rdy[i]), 16'd1);
            chk("midreset_pull_count", pull[i], 16'd0);
        end
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("midreset_no_reward", 16'(vld[1]), 16'd0);

        // Drift on the short-period instance.
        for (int i = 0; i < 4; i++) txn(8'd3, 0);
`ifdef BANDIT_ENVIRONMENT_DRIFT_EN
        chk("drift_best_arm_4", 16'(best[1]), 16'd40);
`else
        chk("nodrift_best_arm_4", 16'(best[1]), 16'd3);
`endif
        for (int i = 0; i < 4; i++) txn(8'd3, 1);
`ifdef BANDIT_ENVIRONMENT_DRIFT_EN
        chk("drift_best_arm_8", 16'(best[1]), 16'd77);
`else
        chk("nodrift_best_arm_8", 16'(best[1]), 16'd3);
`endif
        for (int i = 0; i < 3; i++) txn(8'd3, 0);

        // Threshold boundaries.
        draw_at("a_p255_r255", 8'd255, 8'd3, 0, R_LO);
        draw_at("a_p255_r254", 8'd254, 8'd3, 0, R_HI);
        draw_at("b_high_r204", 8'd204, m_best[1], 1, R_LO);
        draw_at("b_high_r203", 8'd203, m_best[1], 1, R_HI);
        draw_at("b_low_r51", 8'd51, m_best[1] + 8'd1, 1, R_LO);
        draw_at("b_low_r50", 8'd50, m_best[1] + 8'd1, 1, R_HI);
        draw_at("a_p0_r1", 8'd1, 8'd200, 0, R_LO);

        begin
            logic [7:0] arms [6];
            arms = '{8'd3, 8'd7, 8'd40, 8'd77, 8'd0, 8'd255};
            for (int i = 0; i < 90; i++) txn(arms[i % 6], i % 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
